pipe_hazard_sb: RTL and testbench

Parametrised register scoreboard for the decode stage of the pipelined CPU. It tracks every in-flight register write, generates the decode stall (`wpcir`) and per-operand forwarding-bus selects. It replaces hard-coded EX/MEM compare logic with per-register age/readiness state, so it supports any forwarding depth and variable result latencies, for example single-cycle ALU, two-cycle load, or a deeper multiplier. It sits beside the decode stage: its selects drive the operand forwarding muxes, and `wpcir` freezes PC and the IF/ID register.

---
 rtl/pipe_hazard_sb.sv | 146 ++++++++++++++
 tb/tb_pipe_hazard_sb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_sb.sv
// Decode-stage register scoreboard: per-register age/readiness drives the decode stall and the
// operand forwarding selects. Build option: PIPE_HAZ_FWD_EN (forwarding; default build stalls).
module pipe_hazard_sb #(
  parameter int unsigned NREG = 32,
  parameter int unsigned NSTG = 2,
  parameter int unsigned LW   = $clog2(NSTG + 2),
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_wreg,
  input  logic [AW-1:0] id_rn,
  input  logic [LW-1:0] id_lat,
  output logic          wpcir,
  output logic          id_issue,
  output logic [LW-1:0] fwda,
  output logic [LW-1:0] fwdb,
  output logic [31:0]   stall_cnt
);

  logic [NREG-1:0] r_vld;
  logic [LW-1:0]   r_age [NREG];
  logic [31:0]     r_stall_cnt;

  logic [NREG-1:0] w_vld_nxt;
  logic [LW-1:0]   w_age_nxt [NREG];
  logic [31:0]     w_stall_cnt_nxt;

  logic w_hit_rs;
  logic w_hit_rt;
  logic w_haz_rs;
  logic w_haz_rt;
  logic w_alloc;

  // Register 0 is never tracked: its entry stays clear so every lookup of r0 misses.
  assign w_hit_rs = id_use_rs & (id_rs != '0) & r_vld[id_rs];
  assign w_hit_rt = id_use_rt & (id_rt != '0) & r_vld[id_rt];

`ifdef PIPE_HAZ_FWD_EN
  logic [LW-1:0] r_rdy     [NREG];
  logic [LW-1:0] w_rdy_nxt [NREG];
  logic [LW-1:0] w_lat;

  always_comb begin
    if (id_lat == '0) begin
      w_lat = LW'(1);
    end else if (id_lat > LW'(NSTG)) begin
      w_lat = LW'(NSTG);
    end else begin
      w_lat = id_lat;
    end
  end

  assign w_haz_rs = w_hit_rs & (r_age[id_rs] < r_rdy[id_rs]);
  assign w_haz_rt = w_hit_rt & (r_age[id_rt] < r_rdy[id_rt]);
  assign fwda     = w_hit_rs ? r_age[id_rs] : '0;
  assign fwdb     = w_hit_rt ? r_age[id_rt] : '0;
`else
  logic w_unused_lat;

  // Without forwarding a consumer waits until the producer has reached the register file.
  assign w_unused_lat = ^id_lat;
  assign w_haz_rs     = w_hit_rs;
  assign w_haz_rt     = w_hit_rt;
  assign fwda         = '0;
  assign fwdb         = '0;
`endif

  assign wpcir     = ~(id_valid & (w_haz_rs | w_haz_rt));
  assign id_issue  = id_valid & wpcir;
  assign w_alloc   = id_issue & id_wreg & (id_rn != '0);
  assign stall_cnt = r_stall_cnt;

  always_comb begin
    w_vld_nxt = r_vld;
    for (int i = 0; i < NREG; i++) begin
      w_age_nxt[i] = r_age[i];
`ifdef PIPE_HAZ_FWD_EN
      w_rdy_nxt[i] = r_rdy[i];
`endif
    end

    for (int i = 1; i < NREG; i++) begin
      if (r_vld[i]) begin
        if (r_age[i] == LW'(NSTG)) begin
          w_vld_nxt[i] = 1'b0;
          w_age_nxt[i] = '0;
`ifdef PIPE_HAZ_FWD_EN
          w_rdy_nxt[i] = '0;
`endif
        end else begin
          w_age_nxt[i] = r_age[i] + LW'(1);
        end
      end
      // A new writer replaces any older in-flight writer of the same register.
      if (w_alloc && (id_rn == AW'(i))) begin
        w_vld_nxt[i] = 1'b1;
        w_age_nxt[i] = LW'(1);
`ifdef PIPE_HAZ_FWD_EN
        w_rdy_nxt[i] = w_lat;
`endif
      end
    end

    w_vld_nxt[0] = 1'b0;
    w_age_nxt[0] = '0;
`ifdef PIPE_HAZ_FWD_EN
    w_rdy_nxt[0] = '0;
`endif
  end

  always_comb begin
    w_stall_cnt_nxt = r_stall_cnt;
    if (!wpcir && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      w_stall_cnt_nxt = r_stall_cnt + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_vld       <= '0;
      r_stall_cnt <= '0;
      for (int i = 0; i < NREG; i++) begin
        r_age[i] <= '0;
`ifdef PIPE_HAZ_FWD_EN
        r_rdy[i] <= '0;
`endif
      end
    end else begin
      r_vld       <= w_vld_nxt;
      r_stall_cnt <= w_stall_cnt_nxt;
      for (int i = 0; i < NREG; i++) begin
        r_age[i] <= w_age_nxt[i];
`ifdef PIPE_HAZ_FWD_EN
        r_rdy[i] <= w_rdy_nxt[i];
`endif
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_sb.sv
// Scoreboard bench for pipe_hazard_sb: directed decode vectors push expected outputs,
// a negedge monitor pops and compares. Expectations follow PIPE_HAZ_FWD_EN when defined.
module tb_pipe_hazard_sb;

  localparam int unsigned NREG = 32;
  localparam int unsigned NSTG = 2;
  localparam int unsigned LW   = 2;
  localparam int unsigned AW   = 5;

  logic          clock;
  logic          resetn;
  logic          id_valid;
  logic [AW-1:0] id_rs;
  logic [AW-1:0] id_rt;
  logic          id_use_rs;
  logic          id_use_rt;
  logic          id_wreg;
  logic [AW-1:0] id_rn;
  logic [LW-1:0] id_lat;
  logic          wpcir;
  logic          id_issue;
  logic [LW-1:0] fwda;
  logic [LW-1:0] fwdb;
  logic [31:0]   stall_cnt;

  typedef struct packed {
    logic          wp;
    logic          iss;
    logic [LW-1:0] fa;
    logic [LW-1:0] fb;
    logic [31:0]   sc;
  } exp_t;

  exp_t  q_exp  [$];
  string q_name [$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    exp_sc  = 0;

  pipe_hazard_sb #(
    .NREG(NREG),
    .NSTG(NSTG)
  ) u_dut (
    .clock    (clock),
    .resetn   (resetn),
    .id_valid (id_valid),
    .id_rs    (id_rs),
    .id_rt    (id_rt),
    .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt),
    .id_wreg  (id_wreg),
    .id_rn    (id_rn),
    .id_lat   (id_lat),
    .wpcir    (wpcir),
    .id_issue (id_issue),
    .fwda     (fwda),
    .fwdb     (fwdb),
    .stall_cnt(stall_cnt)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic push_exp(input string nm, input int v, input int ewp, input int efa,
                          input int efb);
    exp_t e;
    e.wp  = ewp[0];
    e.iss = v[0] & ewp[0];
    e.fa  = LW'(efa);
    e.fb  = LW'(efb);
    e.sc  = 32'(exp_sc);
    q_exp.push_back(e);
    q_name.push_back(nm);
    if (ewp == 0) exp_sc++;
  endtask

  task automatic drive(input int v, input int rs, input int urs, input int rt, input int urt,
                       input int wr, input int rn, input int lat);
    id_valid  = v[0];
    id_rs     = AW'(rs);
    id_use_rs = urs[0];
    id_rt     = AW'(rt);
    id_use_rt = urt[0];
    id_wreg   = wr[0];
    id_rn     = AW'(rn);
    id_lat    = LW'(lat);
  endtask

  // One decode cycle: drive just after the rising edge, expectation checked at the falling edge.
  task automatic step(input string nm, input int v, input int rs, input int urs, input int rt,
                      input int urt, input int wr, input int rn, input int lat,
                      input int ewp, input int efa, input int efb);
    @(posedge clock);
    #1;
    drive(v, rs, urs, rt, urt, wr, rn, lat);
    push_exp(nm, v, ewp, efa, efb);
  endtask

  // Asserts reset between edges, holding decode inputs, and releases it before the next edge.
  task automatic reset_pulse(input string nm);
    @(negedge clock);
    #1;
    resetn = 1'b0;
    exp_sc = 0;
    push_exp(nm, int'(id_valid), 1, 0, 0);
    @(negedge clock);
    #2;
    resetn = 1'b1;
  endtask

  always @(negedge clock) begin
    if (q_exp.size() != 0) begin
      exp_t  e;
      string nm;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      n_tests++;
      if (wpcir !== e.wp || id_issue !== e.iss || fwda !== e.fa || fwdb !== e.fb ||
          stall_cnt !== e.sc) begin
        n_fail++;
        $display("FAIL %s: got wpcir=%0b issue=%0b fwda=%0d fwdb=%0d stall_cnt=%0d, expected wpcir=%0b issue=%0b fwda=%0d fwdb=%0d stall_cnt=%0d",
                 nm, wpcir, id_issue, fwda, fwdb, stall_cnt, e.wp, e.iss, e.fa, e.fb, e.sc);
      end
    end
  end

  initial begin
    int wait_cyc;
    resetn = 1'b0;
    drive(1, 3, 1, 3, 1, 0, 0, 0);
    #1;
    push_exp("reset_state", 1, 1, 0, 0);
    @(negedge clock);
    #2;
    resetn = 1'b1;

    //   name              v  rs urs rt urt wr rn lat  wp fa fb
`ifdef PIPE_HAZ_FWD_EN
    step("alu_r3",         1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("fwd_age1",       1, 3, 1, 2, 1, 0, 0, 0,  1, 1, 0);
    step("alu_r3_b",       1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("bubble_a",       0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    step("fwd_age2",       1, 3, 1, 0, 0, 0, 0, 0,  1, 2, 0);
    step("alu_r3_c",       1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("bubble_b",       0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    step("bubble_c",       0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);
    step("rf_read_r3",     1, 3, 1, 0, 0, 0, 0, 0,  1, 0, 0);
    step("lw_r5",          1, 1, 1, 2, 1, 1, 5, 2,  1, 0, 0);
    step("load_use_stall", 1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 1);
    step("load_use_issue", 1, 1, 1, 5, 1, 0, 0, 0,  1, 0, 2);
    step("write_r0",       1, 1, 1, 2, 1, 1, 0, 1,  1, 0, 0);
    step("read_r0",        1, 0, 1, 0, 1, 0, 0, 0,  1, 0, 0);
    step("waw_lw_r4",      1, 1, 1, 2, 1, 1, 4, 2,  1, 0, 0);
    step("waw_alu_r4",     1, 1, 1, 2, 1, 1, 4, 1,  1, 0, 0);
    step("waw_read_r4",    1, 4, 1, 0, 0, 0, 0, 0,  1, 1, 0);
    step("alu_r3_d",       1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("no_use_r3",      1, 3, 0, 3, 0, 0, 0, 0,  1, 0, 0);
    step("lat0_alu_r6",    1, 1, 1, 2, 1, 1, 6, 0,  1, 0, 0);
    step("lat0_read_r6",   1, 6, 1, 0, 0, 0, 0, 0,  1, 1, 0);
    step("lat3_op_r7",     1, 1, 1, 2, 1, 1, 7, 3,  1, 0, 0);
    step("lat3_stall",     1, 7, 1, 0, 0, 0, 0, 0,  0, 1, 0);
    step("lat3_issue",     1, 7, 1, 0, 0, 0, 0, 0,  1, 2, 0);
    step("lw_r5_b",        1, 1, 1, 2, 1, 1, 5, 2,  1, 0, 0);
    step("stall_pre_rst",  1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 1);
`else
    step("alu_r3",         1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("nofwd_stall1",   1, 3, 1, 2, 1, 0, 0, 0,  0, 0, 0);
    step("nofwd_stall2",   1, 3, 1, 2, 1, 0, 0, 0,  0, 0, 0);
    step("nofwd_issue",    1, 3, 1, 2, 1, 0, 0, 0,  1, 0, 0);
    step("lw_r5",          1, 1, 1, 2, 1, 1, 5, 2,  1, 0, 0);
    step("load_use_stl1",  1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0);
    step("load_use_stl2",  1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0);
    step("load_use_issue", 1, 1, 1, 5, 1, 0, 0, 0,  1, 0, 0);
    step("write_r0",       1, 1, 1, 2, 1, 1, 0, 1,  1, 0, 0);
    step("read_r0",        1, 0, 1, 0, 1, 0, 0, 0,  1, 0, 0);
    step("waw_lw_r4",      1, 1, 1, 2, 1, 1, 4, 2,  1, 0, 0);
    step("waw_alu_r4",     1, 1, 1, 2, 1, 1, 4, 1,  1, 0, 0);
    step("waw_stall1",     1, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    step("waw_stall2",     1, 4, 1, 0, 0, 0, 0, 0,  0, 0, 0);
    step("waw_issue",      1, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0);
    step("alu_r3_d",       1, 1, 1, 2, 1, 1, 3, 1,  1, 0, 0);
    step("no_use_r3",      1, 3, 0, 3, 0, 0, 0, 0,  1, 0, 0);
    step("lw_r5_b",        1, 1, 1, 2, 1, 1, 5, 2,  1, 0, 0);
    step("stall_pre_rst",  1, 1, 1, 5, 1, 0, 0, 0,  0, 0, 0);
`endif
    reset_pulse("reset_mid_stall");
    step("post_rst_read",  1, 1, 1, 5, 1, 0, 0, 0,  1, 0, 0);
    step("idle_end",       0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0);

    wait_cyc = 0;
    while (q_exp.size() != 0 && wait_cyc < 10) begin
      @(posedge clock);
      wait_cyc++;
    end
    if (q_exp.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q_exp.size());
    end
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
